// File: rtl/fsm_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fsm_sched_pkg
//  Purpose : Shared state encoding, default sizes and round-robin helper for
//            the run/done engine scheduler.
//  Rev     : 1.0  initial release
// ============================================================================
package fsm_sched_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Index reached by stepping 'off' places past 'base', wrapping at 'n'.
    function automatic int rr_index(input int base, input int off, input int n);
        int k;
        k = base + off;
        if (k >= n) begin
            k = k - n;
        end
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_run_sched_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module  : rr_pick
//  Purpose : Combinational round-robin pick. Scans requests starting at the
//            pointer and returns the first set position plus a valid flag.
//  Rev     : 1.0  initial release
// ============================================================================
module rr_pick
    import fsm_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = $clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [ID_W-1:0]  idx_o,
    output logic             valid_o
);

    logic [ID_W-1:0] cand;

    // Walk the search order backwards so the earliest position overwrites later ones.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ID_W'(rr_index(int'(ptr_i), i, N_REQ));
            if (req_i[cand]) begin
                idx_o   = cand;
                valid_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fsm_run_sched.sv
`default_nettype none
// ============================================================================
//  Module  : fsm_run_sched
//  Purpose : Round-robin scheduler sharing one run/done engine among N_REQ
//            requesters, with a WAIT timeout and per-requester acknowledge.
//  Rev     : 1.0  initial release
// ============================================================================
module fsm_run_sched
    import fsm_sched_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int ID_W    = $clog2(N_REQ),
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] in_req,
    input  logic             in_done,
    output logic             out_run,
    output logic [N_REQ-1:0] out_grant,
    output logic [N_REQ-1:0] out_ack,
    output logic             out_timeout,
    output logic             out_busy,
    output logic [ID_W-1:0]  out_last_id
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    state_t          state_q,   state_d;
    logic [ID_W-1:0] ptr_q,     ptr_d;
    logic [ID_W-1:0] owner_q,   owner_d;
    logic [ID_W-1:0] last_id_q, last_id_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic            flag_q,    flag_d;

    logic [ID_W-1:0]  pick_idx;
    logic             pick_valid;
    logic [N_REQ-1:0] owner_oh;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req_i   (in_req),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // State, pointer, owner, counter and completion registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            last_id_q <= '0;
            cnt_q     <= '0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            last_id_q <= last_id_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
        end
    end

    // Next-state logic: grant in IDLE, pulse run, wait for done or timeout, acknowledge.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        last_id_d = last_id_q;
        cnt_d     = cnt_q;
        flag_d    = flag_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    flag_d  = 1'b0;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Done takes priority over a timeout landing in the same cycle.
                if (in_done) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    flag_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                ptr_d     = (owner_q == ID_LAST) ? '0 : owner_q + ID_W'(1);
                last_id_d = owner_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        owner_oh    = N_REQ'(1) << owner_q;
        out_run     = (state_q == ST_LAUNCH);
        out_busy    = (state_q != ST_IDLE);
        out_grant   = (state_q != ST_IDLE) ? owner_oh : '0;
        out_ack     = (state_q == ST_DONE) ? owner_oh : '0;
        out_timeout = (state_q == ST_DONE) && flag_q;
        out_last_id = last_id_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_fsm_run_sched.sv
`default_nettype none
// ============================================================================
//  Module  : tb_fsm_run_sched
//  Purpose : Directed self-checking bench for fsm_run_sched (N_REQ=4,
//            TIMEOUT=8) with a fixed-latency engine model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_fsm_run_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_req;
    logic       in_done;
    logic       out_run;
    logic [3:0] out_grant;
    logic [3:0] out_ack;
    logic       out_timeout;
    logic       out_busy;
    logic [1:0] out_last_id;

    logic       eng_en;
    logic       man_done;
    logic [2:0] eng_sr;

    int n_chk = 0;
    int n_err = 0;
    int lat;

    logic [3:0] fair_exp [6];

    fsm_run_sched #(
        .N_REQ   (4),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_req      (in_req),
        .in_done     (in_done),
        .out_run     (out_run),
        .out_grant   (out_grant),
        .out_ack     (out_ack),
        .out_timeout (out_timeout),
        .out_busy    (out_busy),
        .out_last_id (out_last_id)
    );

    always #5 clk = ~clk;

    // Engine model: done three cycles after the run pulse when enabled.
    always @(posedge clk or posedge rst) begin
        if (rst) eng_sr <= 3'b000;
        else     eng_sr <= {eng_sr[1:0], out_run & eng_en};
    end
    assign in_done = (eng_sr[2] & eng_en) | man_done;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until an ack appears; returns the number of cycles waited.
    task automatic wait_ack(input int max_cyc, output int n);
        n = 0;
        while (out_ack == 4'b0000 && n < max_cyc) begin
            cyc();
            n++;
            chk("grant_onehot", 32'($onehot0(out_grant)), 32'd1);
        end
        chk("ack_seen", 32'(out_ack != 4'b0000), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b1000;
        fair_exp[3] = 4'b0001; fair_exp[4] = 4'b0010; fair_exp[5] = 4'b1000;

        // ---- Reset held with all requests high ----
        rst = 1'b1; in_req = 4'b1111; eng_en = 1'b1; man_done = 1'b0;
        cyc();
        chk("rst_run_c0", 32'(out_run), 32'd0);
        cyc();
        chk("rst_run",     32'(out_run),     32'd0);
        chk("rst_grant",   32'(out_grant),   32'd0);
        chk("rst_ack",     32'(out_ack),     32'd0);
        chk("rst_timeout", 32'(out_timeout), 32'd0);
        chk("rst_busy",    32'(out_busy),    32'd0);
        chk("rst_last_id", 32'(out_last_id), 32'd0);
        rst = 1'b0;
        cyc();
        chk("first_grant", 32'(out_grant), 32'b0001);
        chk("first_run",   32'(out_run),   32'd1);
        in_req = 4'b0000;                 // owner drops request mid-service
        wait_ack(20, lat);
        chk("first_ack",   32'(out_ack),   32'b0001);
        chk("first_lat",   32'(lat),       32'd4);
        cyc();
        chk("first_idle",  32'(out_busy),  32'd0);

        // ---- Single request on requester 2 (ptr=1) ----
        in_req = 4'b0100;                 // cycle 0
        cyc();                            // cycle 1
        chk("single_grant", 32'(out_grant), 32'b0100);
        chk("single_run",   32'(out_run),   32'd1);
        cyc(); cyc(); cyc();              // cycle 4: done from engine
        chk("single_run_once", 32'(out_run), 32'd0);
        chk("single_noack_c4", 32'(out_ack), 32'd0);
        chk("single_done_c4",  32'(in_done), 32'd1);
        cyc();                            // cycle 5
        chk("single_ack",     32'(out_ack),     32'b0100);
        chk("single_to",      32'(out_timeout), 32'd0);
        in_req = 4'b0000;
        cyc();                            // cycle 6
        chk("single_last_id", 32'(out_last_id), 32'd2);
        chk("single_busy",    32'(out_busy),    32'd0);

        // ---- Timeout on requester 1 (ptr=3) ----
        eng_en = 1'b0;
        in_req = 4'b0010;
        cyc();
        chk("to_grant", 32'(out_grant), 32'b0010);
        wait_ack(20, lat);
        chk("to_lat",     32'(lat),         32'd9);
        chk("to_ack",     32'(out_ack),     32'b0010);
        chk("to_flag",    32'(out_timeout), 32'd1);
        in_req = 4'b0000;
        cyc();
        chk("to_flag_clr", 32'(out_timeout), 32'd0);
        chk("to_last_id",  32'(out_last_id), 32'd1);

        // ---- Next request served normally (ptr=2 -> requester 3) ----
        eng_en = 1'b1;
        in_req = 4'b1000;
        cyc();
        chk("post_to_grant", 32'(out_grant), 32'b1000);
        wait_ack(20, lat);
        chk("post_to_lat", 32'(lat),         32'd4);
        chk("post_to_ack", 32'(out_ack),     32'b1000);
        chk("post_to_flg", 32'(out_timeout), 32'd0);
        in_req = 4'b0000;
        cyc();

        // ---- Fairness with 1011 held (ptr=0) ----
        in_req = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("fair_grant", 32'(out_grant), 32'(fair_exp[i]));
            chk("fair_run",   32'(out_run),   32'd1);
            wait_ack(20, lat);
            chk("fair_ack",   32'(out_ack),   32'(fair_exp[i]));
            if (i == 5) in_req = 4'b0000;
            cyc();
            chk("fair_idle",  32'(out_busy),  32'd0);
        end

        // ---- Done on the last WAIT cycle (counter=7) ----
        eng_en = 1'b0;
        in_req = 4'b0001;
        cyc();                            // LAUNCH
        chk("last_grant", 32'(out_grant), 32'b0001);
        repeat (8) cyc();                 // WAIT with counter 7
        chk("last_noack", 32'(out_ack), 32'd0);
        man_done = 1'b1;
        cyc();
        man_done = 1'b0;
        chk("last_ack", 32'(out_ack),     32'b0001);
        chk("last_to",  32'(out_timeout), 32'd0);
        in_req = 4'b0000;
        cyc();

        // ---- Done while idle is ignored ----
        man_done = 1'b1;
        cyc();
        chk("idle_done_busy", 32'(out_busy), 32'd0);
        chk("idle_done_ack",  32'(out_ack),  32'd0);
        man_done = 1'b0;

        // ---- Reset in the middle of WAIT (ptr=1 -> requester 2) ----
        eng_en = 1'b1;
        in_req = 4'b0100;                 // cycle 0
        cyc(); cyc(); cyc();              // cycle 3, WAIT
        chk("mid_grant_pre", 32'(out_grant), 32'b0100);
        rst = 1'b1;
        #1;
        chk("mid_grant_drop", 32'(out_grant), 32'd0);
        chk("mid_busy_drop",  32'(out_busy),  32'd0);
        in_req = 4'b0110;
        cyc();
        chk("mid_noack", 32'(out_ack), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("mid_regrant", 32'(out_grant), 32'b0010);
        wait_ack(20, lat);
        chk("mid_ack", 32'(out_ack), 32'b0010);
        in_req = 4'b0000;
        cyc();
        chk("mid_last_id", 32'(out_last_id), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
